// File: rtl/branch_cmp_ctrl.sv
// branch_cmp_ctrl: decode-stage branch resolution for the pipelined MIPS core.
// beq/bne/bgezal/bonall resolve in the cycle they are presented; lhogez
// (popcount(rs) > POP_THRESH) is counted SLICE_W bits per cycle while F/D is
// stalled, then answered from RESP.
// Optional macro BR_STAT_EN adds the stat_total / stat_taken counters.
module branch_cmp_ctrl #(
  parameter int          SLICE_W    = 8,
  parameter int          POP_THRESH = 8,
  parameter logic [4:0]  OP_BEQ     = 5'd1,
  parameter logic [4:0]  OP_BNE     = 5'd2,
  parameter logic [4:0]  OP_BGEZAL  = 5'd3,
  parameter logic [4:0]  OP_BONALL  = 5'd4,
  parameter logic [4:0]  OP_LHOGEZ  = 5'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [4:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        src_ready,
  input  logic        flush,
  output logic        stall,
  output logic        resp_valid,
  output logic        taken,
  output logic        busy
`ifdef BR_STAT_EN
  ,
  output logic [31:0] stat_total,
  output logic [31:0] stat_taken
`endif
);

  localparam int         N      = 32 / SLICE_W;
  localparam logic [3:0] LAST   = 4'(N - 1);
  localparam logic [5:0] THRESH = 6'(POP_THRESH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COUNT, ST_RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] shift_reg;
  logic [5:0]  pop_cnt;
  logic [3:0]  slice_cnt;

  logic        eval_en;
  logic        lhz_accept;
  logic        simple_taken;
  logic [31:0] sum_ab;
  logic signed [31:0] a_s;

  // Popcount of the low SLICE_W bits of the shift register.
  function automatic logic [5:0] pop_slice(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < SLICE_W; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  // Single-cycle comparisons and the evaluate/accept qualifiers.
  always_comb begin
    sum_ab       = src_a + src_b;
    a_s          = src_a;
    simple_taken = 1'b0;
    case (req_op)
      OP_BEQ:    simple_taken = (src_a == src_b);
      OP_BNE:    simple_taken = (src_a != src_b);
      OP_BGEZAL: simple_taken = (a_s >= 32'sd0);
      OP_BONALL: simple_taken = (sum_ab == 32'd0);
      default:   simple_taken = 1'b0;
    endcase
    eval_en    = !flush && src_ready &&
                 (((state == ST_IDLE) && req_valid) || (state == ST_WAIT));
    lhz_accept = eval_en && (req_op == OP_LHOGEZ);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (!src_ready)      state_nxt = ST_WAIT;
            else if (lhz_accept) state_nxt = ST_COUNT;
            else                 state_nxt = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (src_ready) state_nxt = lhz_accept ? ST_COUNT : ST_IDLE;
        end
        ST_COUNT: begin
          if (slice_cnt == LAST) state_nxt = ST_RESP;
        end
        ST_RESP:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs; reset and flush force the handshake outputs low combinationally.
  always_comb begin
    stall      = 1'b0;
    resp_valid = 1'b0;
    taken      = 1'b0;
    busy       = reset && (state != ST_IDLE);
    if (reset && !flush) begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          if ((state == ST_WAIT) || req_valid) begin
            if (!src_ready) begin
              stall = 1'b1;
            end else if (req_op == OP_LHOGEZ) begin
              stall = 1'b1;
            end else begin
              resp_valid = 1'b1;
              taken      = simple_taken;
            end
          end
        end
        ST_COUNT: stall = 1'b1;
        ST_RESP: begin
          resp_valid = 1'b1;
          taken      = (pop_cnt > THRESH);
        end
        default: ;
      endcase
    end
  end

  // lhogez datapath: latch rs on accept, then accumulate one slice per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      pop_cnt   <= '0;
      slice_cnt <= '0;
    end else if (flush) begin
      pop_cnt   <= '0;
      slice_cnt <= '0;
    end else if (lhz_accept) begin
      shift_reg <= src_a;
      pop_cnt   <= '0;
      slice_cnt <= '0;
    end else if (state == ST_COUNT) begin
      pop_cnt   <= pop_cnt + pop_slice(shift_reg);
      shift_reg <= shift_reg >> SLICE_W;
      slice_cnt <= slice_cnt + 4'd1;
    end
  end

`ifdef BR_STAT_EN
  // Decision statistics; survive flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (resp_valid) begin
      stat_total <= stat_total + 32'd1;
      if (taken) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// Directed bench for branch_cmp_ctrl (SLICE_W=8, POP_THRESH=8).
// Each step drives inputs just after a rising edge and checks
// {stall, resp_valid, taken, busy} mid-cycle against hand-computed values.
module tb_branch_cmp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [4:0]  req_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        src_ready;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic        taken;
  logic        busy;
`ifdef BR_STAT_EN
  logic [31:0] stat_total;
  logic [31:0] stat_taken;
`endif

  int checks = 0;
  int errors = 0;
  int exp_total = 0;
  int exp_taken = 0;

  localparam logic [4:0] BEQ = 5'd1, BNE = 5'd2, BGEZAL = 5'd3, BONALL = 5'd4, LHOGEZ = 5'd5;

  branch_cmp_ctrl #(.SLICE_W(8), .POP_THRESH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .src_a      (src_a),
    .src_b      (src_b),
    .src_ready  (src_ready),
    .flush      (flush),
    .stall      (stall),
    .resp_valid (resp_valid),
    .taken      (taken),
    .busy       (busy)
`ifdef BR_STAT_EN
    ,
    .stat_total (stat_total),
    .stat_taken (stat_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy, input logic fl);
    req_valid = v;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    src_ready = rdy;
    flush     = fl;
  endtask

  // exp = {stall, resp_valid, taken, busy}
  task automatic step(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    #4;
    obs = {stall, resp_valid, taken, busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: {stall,resp_valid,taken,busy} got %b expected %b", tag, obs, exp);
    end
`ifdef BR_STAT_EN
    if (!reset) begin
      exp_total = 0;
      exp_taken = 0;
    end
    checks++;
    assert ({stat_total, stat_taken} === {32'(exp_total), 32'(exp_taken)}) else begin
      errors++;
      $error("FAIL %s_stat: total/taken got %0d/%0d expected %0d/%0d",
             tag, stat_total, stat_taken, exp_total, exp_taken);
    end
    if (exp[2]) begin
      exp_total++;
      if (exp[1]) exp_taken++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, BEQ, 32'h1234, 32'h1234, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    step("reset_hold", 4'b0000);
    reset = 1'b1;

    // Single-cycle ops
    drive(1'b1, BEQ, 32'h1234, 32'h1234, 1'b1, 1'b0);                step("beq_eq", 4'b0110);
    drive(1'b1, BNE, 32'h1234, 32'h1234, 1'b1, 1'b0);                step("bne_eq", 4'b0100);
    drive(1'b1, BONALL, 32'h0000_0005, 32'hFFFF_FFFB, 1'b1, 1'b0);   step("bonall_zero", 4'b0110);
    drive(1'b1, BONALL, 32'h0000_0005, 32'hFFFF_FFFA, 1'b1, 1'b0);   step("bonall_nz", 4'b0100);
    drive(1'b1, BGEZAL, 32'h8000_0000, 32'h0, 1'b1, 1'b0);           step("bgezal_neg", 4'b0100);
    drive(1'b1, BGEZAL, 32'h0, 32'h0, 1'b1, 1'b0);                   step("bgezal_zero", 4'b0110);
    drive(1'b1, 5'd9, 32'h55, 32'h55, 1'b1, 1'b0);                   step("unknown_op", 4'b0100);
    drive(1'b0, BEQ, 32'h55, 32'h55, 1'b1, 1'b0);                    step("idle", 4'b0000);

    // lhogez, 9 ones -> taken; COUNT ignores op/operands
    drive(1'b1, LHOGEZ, 32'h0000_01FF, 32'h0, 1'b1, 1'b0);           step("lhz9_c0", 4'b1000);
    drive(1'b1, BEQ, 32'h0, 32'h0, 1'b0, 1'b0);                      step("lhz9_c1", 4'b1001);
    step("lhz9_c2", 4'b1001);
    step("lhz9_c3", 4'b1001);
    step("lhz9_c4", 4'b1001);
    drive(1'b1, LHOGEZ, 32'h0, 32'h0, 1'b1, 1'b0);                   step("lhz9_resp", 4'b0111);
    // back-to-back branch right after RESP
    drive(1'b1, BEQ, 32'h77, 32'h77, 1'b1, 1'b0);                    step("b2b_beq", 4'b0110);

    // lhogez, 8 ones -> not taken (strictly greater)
    drive(1'b1, LHOGEZ, 32'h0000_00FF, 32'h0, 1'b1, 1'b0);           step("lhz8_c0", 4'b1000);
    drive(1'b1, LHOGEZ, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);           step("lhz8_c1", 4'b1001);
    step("lhz8_c2", 4'b1001);
    step("lhz8_c3", 4'b1001);
    step("lhz8_c4", 4'b1001);
    step("lhz8_resp", 4'b0101);
    drive(1'b0, BEQ, 32'h0, 32'h0, 1'b1, 1'b0);                      step("lhz8_after", 4'b0000);

    // WAIT: operands not final for 3 cycles, 4th-cycle operands decide
    drive(1'b1, BEQ, 32'h1, 32'h2, 1'b0, 1'b0);                      step("wait_c0", 4'b1000);
    step("wait_c1", 4'b1001);
    step("wait_c2", 4'b1001);
    drive(1'b1, BEQ, 32'h7, 32'h7, 1'b1, 1'b0);                      step("wait_res", 4'b0111);
    drive(1'b0, BEQ, 32'h0, 32'h0, 1'b1, 1'b0);                      step("wait_after", 4'b0000);

    // Flush during COUNT
    drive(1'b1, LHOGEZ, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);           step("fl_c0", 4'b1000);
    step("fl_c1", 4'b1001);
    drive(1'b1, LHOGEZ, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);           step("fl_c2", 4'b0001);
    drive(1'b0, LHOGEZ, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 3; i < 8; i++) step("fl_quiet", 4'b0000);

    // Flush beats req_valid in IDLE
    drive(1'b1, BEQ, 32'h3, 32'h3, 1'b1, 1'b1);                      step("fl_idle", 4'b0000);
    drive(1'b0, BEQ, 32'h3, 32'h3, 1'b1, 1'b0);                      step("fl_idle_after", 4'b0000);

    // Reset mid-COUNT
    drive(1'b1, LHOGEZ, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);           step("rc_c0", 4'b1000);
    step("rc_c1", 4'b1001);
    reset = 1'b0;                                                    step("rc_reset", 4'b0000);
    reset = 1'b1;
    drive(1'b0, BEQ, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("rc_quiet", 4'b0000);

    // Full word of ones: popcount 32 -> taken
    drive(1'b1, LHOGEZ, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);           step("lhz32_c0", 4'b1000);
    for (int i = 1; i < 5; i++) step("lhz32_cnt", 4'b1001);
    step("lhz32_resp", 4'b0111);
    drive(1'b0, BEQ, 32'h0, 32'h0, 1'b1, 1'b0);                      step("lhz32_after", 4'b0000);

`ifdef BR_STAT_EN
    // Fresh statistics: beq-taken, bne-not-taken, lhogez-taken, then a flush
    reset = 1'b0;                                                    step("st_reset", 4'b0000);
    reset = 1'b1;
    drive(1'b1, BEQ, 32'h9, 32'h9, 1'b1, 1'b0);                      step("st_beq", 4'b0110);
    drive(1'b1, BNE, 32'h9, 32'h9, 1'b1, 1'b0);                      step("st_bne", 4'b0100);
    drive(1'b1, LHOGEZ, 32'h0000_03FF, 32'h0, 1'b1, 1'b0);           step("st_lhz_c0", 4'b1000);
    for (int i = 1; i < 5; i++) step("st_lhz_cnt", 4'b1001);
    step("st_lhz_resp", 4'b0111);
    drive(1'b1, BEQ, 32'h1, 32'h1, 1'b1, 1'b1);                      step("st_flush", 4'b0000);
    drive(1'b0, BEQ, 32'h0, 32'h0, 1'b1, 1'b0);                      step("st_final", 4'b0000);
    checks++;
    assert ({stat_total, stat_taken} === {32'd3, 32'd2}) else begin
      errors++;
      $error("FAIL st_abs: total/taken got %0d/%0d expected 3/2", stat_total, stat_taken);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
